// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared loader/instruction-memory constants and state encoding
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_ERR   = 3'd5,
        ST_DONE  = 3'd6
    } load_state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         IMEM_DEPTH = 256;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory writer with CPU hold
module imem_loader
    import mips_pkg::*;
#(
    parameter int         ADDR_W  = 16,
    parameter int         DEPTH   = IMEM_DEPTH,
    parameter int         TIMEOUT = 1000,
    parameter logic [7:0] SYNC    = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = ADDR_W + 1;

    load_state_t       state, state_next;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       word;
    logic [1:0]        bcnt;
    logic [7:0]        csum;
    logic [TW-1:0]     tmo;

    logic        xfer;
    logic        in_frame;
    logic        timed_out;
    logic        last_word;
    logic        is_sync;
    logic [15:0] cnt_full;
    logic [CW-1:0] widx_inc;

    assign xfer      = rx_valid & rx_ready;
    assign is_sync   = (rx_data == SYNC);
    assign cnt_full  = {cnt[7:0], rx_data};
    assign widx_inc  = CW'(widx) + CW'(1);
    assign last_word = (widx_inc == CW'(cnt));
    assign in_frame  = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    // tmo counts idle cycles already seen; this cycle would be number TIMEOUT
    assign timed_out = in_frame && !xfer && (tmo == TW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (xfer && is_sync) state_next = ST_HDR;
            ST_HDR: begin
                if (xfer && bcnt == 2'd1) begin
                    if (cnt_full == 16'd0 || 32'(cnt_full) > DEPTH) state_next = ST_ERR;
                    else                                           state_next = ST_DATA;
                end
            end
            ST_DATA:  if (xfer && bcnt == 2'd3) state_next = ST_WRITE;
            ST_WRITE: state_next = last_word ? ST_CSUM : ST_DATA;
            ST_CSUM:  if (xfer) state_next = (rx_data == csum) ? ST_DONE : ST_ERR;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (timed_out) state_next = ST_ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            cnt        <= '0;
            widx       <= '0;
            word       <= '0;
            bcnt       <= '0;
            csum       <= '0;
            tmo        <= '0;
        end else begin
            state    <= state_next;
            rx_ready <= (state_next != ST_WRITE) && (state_next != ST_ERR);
            imem_we  <= (state_next == ST_WRITE);
            tmo      <= (xfer || !in_frame) ? '0 : tmo + TW'(1);

            if (xfer) begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (is_sync) begin
                            bcnt      <= '0;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        cnt  <= cnt_full;
                        bcnt <= (bcnt == 2'd1) ? 2'd0 : bcnt + 2'd1;
                        widx <= '0;
                        csum <= '0;
                    end
                    ST_DATA: begin
                        word <= {word[23:0], rx_data};
                        csum <= csum ^ rx_data;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            imem_addr  <= widx;
                            imem_wdata <= {word[23:0], rx_data};
                        end
                    end
                    default: ;
                endcase
            end

            if (state == ST_WRITE) widx <= widx + ADDR_W'(1);

            if (state == ST_CSUM && state_next == ST_DONE) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end
            if (state_next == ST_ERR && state != ST_ERR) begin
                load_err <= 1'b1;
                cpu_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frame bench for imem_loader against a frame-level model
module tb_imem_loader;

    localparam int TIMEOUT = 1000;
    localparam int DEPTH   = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_loader #(.ADDR_W(16), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] word_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] wdata_q[$];
    logic [15:0] waddr_q[$];
    logic        exp_done;
    logic        exp_err;
    bit          count_en = 1'b0;
    int          rdy_low;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && imem_we) begin
            waddr_q.push_back(imem_addr);
            wdata_q.push_back(imem_wdata);
        end
        if (count_en && !rx_ready) rdy_low++;
    end

    // Frame-level model: which words land in IM and how the frame ends.
    task automatic model_frame();
        int          cnt;
        logic [7:0]  x;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b1;
        x        = 8'h00;
        if (frame_q.size() < 3) return;
        cnt = frame_q[1] * 256 + frame_q[2];
        if (cnt == 0 || cnt > DEPTH) return;
        for (int i = 0; i < cnt; i++) begin
            if (3 + 4 * i + 3 < frame_q.size())
                exp_q.push_back({frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i], frame_q[6+4*i]});
        end
        for (int i = 3; i < frame_q.size() && i < 3 + 4 * cnt; i++) x ^= frame_q[i];
        if (frame_q.size() == 4 + 4 * cnt) begin
            exp_err  = (frame_q[3 + 4 * cnt] != x);
            exp_done = !exp_err;
        end
    endtask

    task automatic build_frame(input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(word_q.size() >> 8));
        frame_q.push_back(8'(word_q.size()));
        foreach (word_q[i]) begin
            for (int k = 3; k >= 0; k--) begin
                b = word_q[i][8*k +: 8];
                frame_q.push_back(b);
                x ^= b;
            end
        end
        frame_q.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic rand_words(input int cnt);
        word_q.delete();
        for (int i = 0; i < cnt; i++) word_q.push_back($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        bit acc;
        acc = 1'b0;
        if (gappy) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        rx_valid = 1'b0;
        if (!acc) chk("rx_accept", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input string tag, input bit gappy, input bit check_rdy);
        model_frame();
        waddr_q.delete();
        wdata_q.delete();
        rdy_low  = 0;
        count_en = 1'b1;
        foreach (frame_q[i]) send_byte(frame_q[i], gappy);
        count_en = 1'b0;
        chk({tag, ".n_writes"}, 32'(wdata_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wdata_q.size(); i++) begin
            chk({tag, ".waddr"}, 32'(waddr_q[i]), 32'(i));
            chk({tag, ".wdata"}, wdata_q[i], exp_q[i]);
        end
        chk({tag, ".done"}, 32'(load_done), 32'(exp_done));
        chk({tag, ".err"},  32'(load_err),  32'(exp_err));
        chk({tag, ".hold"}, 32'(cpu_hold),  32'(!exp_done));
        if (check_rdy) chk({tag, ".rdy_low"}, 32'(rdy_low), 32'(exp_q.size()));
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rx_ready", 32'(rx_ready),  32'd0);
        chk("rst.we",       32'(imem_we),   32'd0);
        chk("rst.addr",     32'(imem_addr), 32'd0);
        chk("rst.wdata",    imem_wdata,     32'd0);
        chk("rst.hold",     32'(cpu_hold),  32'd1);
        chk("rst.done",     32'(load_done), 32'd0);
        chk("rst.err",      32'(load_err),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.rdy_still_low", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst.rdy_rise", 32'(rx_ready), 32'd1);

        word_q = '{32'hDEADBEEF};
        build_frame(1'b0);
        chk("t1.csum_byte", 32'(frame_q[7]), 32'h22);
        run_frame("t1", 1'b0, 1'b1);
        chk("t1.first_word", wdata_q.size() > 0 ? wdata_q[0] : 32'hx, 32'hDEADBEEF);

        word_q = '{32'd1, 32'd2, 32'd3};
        build_frame(1'b0);
        run_frame("t2", 1'b1, 1'b1);

        rand_words(2);
        build_frame(1'b1);
        run_frame("t3.bad", 1'b1, 1'b0);
        rand_words(3);
        build_frame(1'b0);
        run_frame("t3.good", 1'b1, 1'b1);

        frame_q = '{8'hA5, 8'h00, 8'h00};
        run_frame("t4.zero", 1'b0, 1'b0);
        frame_q = '{8'hA5, 8'h01, 8'h01};
        run_frame("t4.over", 1'b0, 1'b0);

        rand_words(DEPTH);
        build_frame(1'b0);
        run_frame("depth", 1'b0, 1'b1);

        word_q = '{32'hA5A5A5A5, 32'h00A50000};
        build_frame(1'b0);
        run_frame("sync_in_data", 1'b1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            rand_words($urandom_range(1, 6));
            build_frame($urandom_range(0, 3) == 0);
            run_frame("rand", 1'b1, 1'b1);
        end

        // stall after the 2nd data byte
        rand_words(2);
        build_frame(1'b0);
        waddr_q.delete();
        wdata_q.delete();
        for (int i = 0; i < 5; i++) send_byte(frame_q[i], 1'b0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("t5.err_before", 32'(load_err), 32'd0);
        @(posedge clk); #1;
        chk("t5.err",  32'(load_err), 32'd1);
        chk("t5.hold", 32'(cpu_hold), 32'd1);
        @(posedge clk); #1;
        chk("t5.idle_rdy", 32'(rx_ready), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        chk("t5.garbage_err",  32'(load_err),  32'd1);
        chk("t5.garbage_done", 32'(load_done), 32'd0);
        chk("t5.no_writes",    32'(wdata_q.size()), 32'd0);
        rand_words(2);
        build_frame(1'b0);
        run_frame("t5.fresh", 1'b1, 1'b1);

        // reset in the middle of DATA, after one word has already been written
        rand_words(2);
        build_frame(1'b0);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i], 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6.rx_ready", 32'(rx_ready),  32'd0);
        chk("t6.we",       32'(imem_we),   32'd0);
        chk("t6.addr",     32'(imem_addr), 32'd0);
        chk("t6.wdata",    imem_wdata,     32'd0);
        chk("t6.hold",     32'(cpu_hold),  32'd1);
        chk("t6.done",     32'(load_done), 32'd0);
        chk("t6.err",      32'(load_err),  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        rand_words(1);
        build_frame(1'b0);
        run_frame("t6.load", 1'b0, 1'b1);
        send_byte(8'hA5, 1'b0);
        chk("t6.resync_hold", 32'(cpu_hold),  32'd1);
        chk("t6.resync_done", 32'(load_done), 32'd0);
        rand_words(1);
        build_frame(1'b0);
        frame_q.pop_front();
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b0);
        chk("t6.reload_done", 32'(load_done), 32'd1);
        chk("t6.reload_hold", 32'(cpu_hold),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
